// File: rtl/decode_stage_pipe_if.sv
// Fetch/write-back/execute signal bundle for the decode stage.
// master = the surrounding pipeline, slave = the decode stage itself.
interface decode_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst;
    logic [XLEN-1:0]   pc;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_mem_to_reg;
    logic [XLEN-1:0]   wb_mem_data;
    logic [XLEN-1:0]   wb_alu_result;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_rs1_data;
    logic [XLEN-1:0]   out_rs2_data;
    logic [XLEN-1:0]   out_imm;
    logic [REG_AW-1:0] out_rd;
    logic [6:0]        out_opcode;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [XLEN-1:0]   out_pc;

    modport master (
        output in_valid, inst, pc, wb_en, wb_rd, wb_mem_to_reg, wb_mem_data,
               wb_alu_result, flush, out_ready,
        input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_imm,
               out_rd, out_opcode, out_funct3, out_funct7, out_pc
    );

    modport slave (
        input  in_valid, inst, pc, wb_en, wb_rd, wb_mem_to_reg, wb_mem_data,
               wb_alu_result, flush, out_ready,
        output in_ready, out_valid, out_rs1_data, out_rs2_data, out_imm,
               out_rd, out_opcode, out_funct3, out_funct7, out_pc
    );
endinterface

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: write-first register file, immediate generation and a
// registered valid/ready output slot with stall-time operand refresh and flush.
module decode_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst,
    decode_stage_pipe_if.slave bus
);
    localparam int NREG = 2 ** REG_AW;

    typedef struct packed {
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1_idx;
        logic [REG_AW-1:0] rs2_idx;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
    } bundle_t;

    function automatic logic is_zero(input logic [REG_AW-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // Widen a 32-bit two's-complement value to XLEN (XLEN >= 32).
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-31){v[31]}}, v[30:0]};
    endfunction

    logic [XLEN-1:0]   regs_q [NREG];
    logic [XLEN-1:0]   regs_d [NREG];
    logic              out_valid_q, out_valid_d;
    bundle_t           bundle_q, bundle_d;

    logic [31:0]       inst;
    logic [XLEN-1:0]   wb_data;
    logic              wb_write;
    logic [REG_AW-1:0] rs1_idx, rs2_idx;
    logic [XLEN-1:0]   rs1_val, rs2_val, imm;
    logic              in_ready, accept;

    assign inst     = bus.inst;
    assign rs1_idx  = inst[15 +: REG_AW];
    assign rs2_idx  = inst[20 +: REG_AW];
    assign wb_data  = bus.wb_mem_to_reg ? bus.wb_mem_data : bus.wb_alu_result;
    assign wb_write = bus.wb_en && !is_zero(bus.wb_rd);

    assign in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Write-first read ports: a same-cycle write-back is forwarded.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rs1_val = regs_q[rs1_idx];
        rs2_val = regs_q[rs2_idx];
        if (wb_write && bus.wb_rd == rs1_idx) rs1_val = wb_data;
        if (wb_write && bus.wb_rd == rs2_idx) rs2_val = wb_data;
        if (is_zero(rs1_idx)) rs1_val = '0;
        if (is_zero(rs2_idx)) rs2_val = '0;
    end

    always_comb begin
        imm = '0;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                imm = sext32({{20{inst[31]}}, inst[31:20]});
            7'b0100011:
                imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
            7'b1100011:
                imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
            7'b0110111, 7'b0010111:
                imm = sext32({inst[31:12], 12'b0});
            7'b1101111:
                imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
            default:
                imm = '0;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_write) regs_d[bus.wb_rd] = wb_data;
    end

    // Flush wins over load, drain and stall; a stalled slot tracks write-backs.
    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d       = 1'b1;
            bundle_d.rs1_data = rs1_val;
            bundle_d.rs2_data = rs2_val;
            bundle_d.imm      = imm;
            bundle_d.pc       = bus.pc;
            bundle_d.rd       = inst[7 +: REG_AW];
            bundle_d.rs1_idx  = rs1_idx;
            bundle_d.rs2_idx  = rs2_idx;
            bundle_d.opcode   = inst[6:0];
            bundle_d.funct3   = inst[14:12];
            bundle_d.funct7   = inst[31:25];
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            if (wb_write && bus.wb_rd == bundle_q.rs1_idx) bundle_d.rs1_data = wb_data;
            if (wb_write && bus.wb_rd == bundle_q.rs2_idx) bundle_d.rs2_data = wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            // NOTE: the register file is reset too, so every register reads zero straight out of reset.
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            regs_q      <= regs_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_rs1_data = bundle_q.rs1_data;
    assign bus.out_rs2_data = bundle_q.rs2_data;
    assign bus.out_imm      = bundle_q.imm;
    assign bus.out_rd       = bundle_q.rd;
    assign bus.out_opcode   = bundle_q.opcode;
    assign bus.out_funct3   = bundle_q.funct3;
    assign bus.out_funct7   = bundle_q.funct7;
    assign bus.out_pc       = bundle_q.pc;
endmodule
